// File: rtl/dpram_rr_arbiter_pkg.sv
// Shared constants for the dual-port RAM round-robin arbiter:
// default geometry and the layout of the per-port request tag.
package dpram_arb_pkg;

   localparam int DEF_N  = 4;
   localparam int DEF_AW = 6;
   localparam int DEF_DW = 8;

   // Tag layout, LSB first: valid, is_read, then the requester index.
   localparam int TAG_VALID = 0;
   localparam int TAG_RD    = 1;
   localparam int TAG_IDX   = 2;

   // Width of a requester index; at least one bit so N=1 stays legal.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Total tag width for n requesters.
   function automatic int tag_w(input int n);
      return TAG_IDX + idx_w(n);
   endfunction

endpackage

// File: rtl/dpram_rr_arbiter_if.sv
// Requester-side bus of the arbiter: flattened request fields in,
// combinational grants and read responses out.
interface dpram_rr_arbiter_if
   import dpram_arb_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
);
   logic [N-1:0]    req;
   logic [N-1:0]    we;
   logic [N*AW-1:0] addr;
   logic [N*DW-1:0] wdata;
   logic [N-1:0]    gnt;
   logic [N-1:0]    rvalid;
   logic [N*DW-1:0] rdata;

   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dpram_rr_arbiter_pick2.sv
// Round-robin picker: finds the first two active requesters scanning
// upward from ptr with wrap-around. Purely combinational.
module rr_pick2 #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  pri_oh,
   output logic [N-1:0]  sec_oh,
   output logic          pri_vld,
   output logic          sec_vld
);

   logic [IW-1:0] j;

   // Scan from ptr, first hit is primary, second hit is secondary.
   always_comb begin
      pri_oh  = '0;
      sec_oh  = '0;
      pri_vld = 1'b0;
      sec_vld = 1'b0;
      j       = '0;
      for (int k = 0; k < N; k++) begin
         j = IW'((int'(ptr) + k) % N);
         if (req[j]) begin
            if (!pri_vld) begin
               pri_oh[j] = 1'b1;
               pri_vld   = 1'b1;
            end else if (!sec_vld) begin
               sec_oh[j] = 1'b1;
               sec_vld   = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/dpram_rr_arbiter.sv
// Arbiter sharing the two ports of a 64x8 dual-port RAM among N
// requesters: up to two grants per cycle (primary on port A, secondary
// on port B), same-address write collisions blocked, read data routed
// back to the requester that issued it two cycles after the grant.
module dpram_rr_arbiter
   import dpram_arb_pkg::*;
#(
   parameter int N  = DEF_N,
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
) (
   input  logic          clk,
   input  logic          rst_n,
   dpram_rr_arbiter_if.slave bus,
   output logic [AW-1:0] ram_addr_a,
   output logic [AW-1:0] ram_addr_b,
   output logic [DW-1:0] ram_data_a,
   output logic [DW-1:0] ram_data_b,
   output logic          ram_we_a,
   output logic          ram_we_b,
   input  logic [DW-1:0] ram_q_a,
   input  logic [DW-1:0] ram_q_b
);

   localparam int IW = idx_w(N);
   localparam int TW = tag_w(N);

   logic [IW-1:0]   ptr;
   logic [IW-1:0]   ptr_nxt;
   logic [N-1:0]    pri_oh;
   logic [N-1:0]    sec_oh;
   logic            pri_vld;
   logic            sec_vld;
   logic [IW-1:0]   pri_idx;
   logic [IW-1:0]   sec_idx;
   logic [IW-1:0]   last_idx;
   logic [AW-1:0]   pri_addr;
   logic [AW-1:0]   sec_addr;
   logic [DW-1:0]   pri_wdata;
   logic [DW-1:0]   sec_wdata;
   logic            pri_we;
   logic            sec_we;
   logic            sec_gnt;
   logic [TW-1:0]   tag_a_p1;
   logic [TW-1:0]   tag_b_p1;
   logic [TW-1:0]   tag_a_p2;
   logic [TW-1:0]   tag_b_p2;
   logic [N*DW-1:0] rdata_hold;
   logic [N*DW-1:0] rdata_cur;
   logic [N-1:0]    rvalid_cur;

   rr_pick2 #(.N(N), .IW(IW)) u_pick (
      .req     (bus.req),
      .ptr     (ptr),
      .pri_oh  (pri_oh),
      .sec_oh  (sec_oh),
      .pri_vld (pri_vld),
      .sec_vld (sec_vld)
   );

   // Pull index and request fields of the two picks, then apply the
   // collision rule: only a read/read pair may share an address.
   always_comb begin
      pri_idx   = '0;
      sec_idx   = '0;
      pri_addr  = '0;
      sec_addr  = '0;
      pri_wdata = '0;
      sec_wdata = '0;
      pri_we    = 1'b0;
      sec_we    = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (pri_oh[i]) begin
            pri_idx   = IW'(i);
            pri_addr  = bus.addr[i*AW +: AW];
            pri_wdata = bus.wdata[i*DW +: DW];
            pri_we    = bus.we[i];
         end
         if (sec_oh[i]) begin
            sec_idx   = IW'(i);
            sec_addr  = bus.addr[i*AW +: AW];
            sec_wdata = bus.wdata[i*DW +: DW];
            sec_we    = bus.we[i];
         end
      end
      sec_gnt  = sec_vld && !((pri_addr == sec_addr) && (pri_we || sec_we));
      last_idx = sec_gnt ? sec_idx : pri_idx;
      ptr_nxt  = (int'(last_idx) == N - 1) ? '0 : last_idx + 1'b1;
      // Grants are forced low while reset is held so nothing is consumed.
      bus.gnt  = '0;
      if (rst_n) begin
         bus.gnt = (pri_vld ? pri_oh : '0) | (sec_gnt ? sec_oh : '0);
      end
   end

   // Pointer moves just past the last granted requester; holds when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (pri_vld) begin
         ptr <= ptr_nxt;
      end
   end

   // ---- stage 1: granted requests drive the RAM pins, tags follow ----

   // Port A carries the primary grant; address/data hold when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_addr_a <= '0;
         ram_data_a <= '0;
         ram_we_a   <= 1'b0;
         tag_a_p1   <= '0;
      end else if (pri_vld) begin
         ram_addr_a                 <= pri_addr;
         ram_data_a                 <= pri_wdata;
         ram_we_a                   <= pri_we;
         tag_a_p1[TAG_VALID]        <= 1'b1;
         tag_a_p1[TAG_RD]           <= !pri_we;
         tag_a_p1[TAG_IDX +: IW]    <= pri_idx;
      end else begin
         ram_we_a <= 1'b0;
         tag_a_p1 <= '0;
      end
   end

   // Port B carries the secondary grant when it survives the collision rule.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ram_addr_b <= '0;
         ram_data_b <= '0;
         ram_we_b   <= 1'b0;
         tag_b_p1   <= '0;
      end else if (sec_gnt) begin
         ram_addr_b                 <= sec_addr;
         ram_data_b                 <= sec_wdata;
         ram_we_b                   <= sec_we;
         tag_b_p1[TAG_VALID]        <= 1'b1;
         tag_b_p1[TAG_RD]           <= !sec_we;
         tag_b_p1[TAG_IDX +: IW]    <= sec_idx;
      end else begin
         ram_we_b <= 1'b0;
         tag_b_p1 <= '0;
      end
   end

   // ---- stage 2: tags line up with the RAM's registered q ----

   // Tags advance on the same edge the RAM performs the access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_a_p2 <= '0;
         tag_b_p2 <= '0;
      end else begin
         tag_a_p2 <= tag_a_p1;
         tag_b_p2 <= tag_b_p1;
      end
   end

   // Route q to the lane named by each read tag. Both sources are flops
   // (stage-2 tags and the RAM output register), so responses land two
   // cycles after the grant; lanes without a pulse show their held value.
   always_comb begin
      rvalid_cur = '0;
      rdata_cur  = rdata_hold;
      for (int i = 0; i < N; i++) begin
         if (tag_b_p2[TAG_VALID] && tag_b_p2[TAG_RD] &&
             tag_b_p2[TAG_IDX +: IW] == IW'(i)) begin
            rvalid_cur[i]         = 1'b1;
            rdata_cur[i*DW +: DW] = ram_q_b;
         end
         if (tag_a_p2[TAG_VALID] && tag_a_p2[TAG_RD] &&
             tag_a_p2[TAG_IDX +: IW] == IW'(i)) begin
            rvalid_cur[i]         = 1'b1;
            rdata_cur[i*DW +: DW] = ram_q_a;
         end
      end
      bus.rvalid = rvalid_cur;
      bus.rdata  = rdata_cur;
   end

   // Remember the last delivered word per lane.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_hold <= '0;
      end else begin
         rdata_hold <= rdata_cur;
      end
   end

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// Bench for dpram_rr_arbiter: behavioural 64x8 dual-port RAM, directed
// scenarios, and a scoreboard of expected read responses.
module tb_dpram_rr_arbiter;
   import dpram_arb_pkg::*;

   localparam int N  = 4;
   localparam int AW = 6;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] ram_addr_a, ram_addr_b;
   logic [DW-1:0] ram_data_a, ram_data_b;
   logic          ram_we_a, ram_we_b;
   logic [DW-1:0] ram_q_a = '0;
   logic [DW-1:0] ram_q_b = '0;
   logic [DW-1:0] mem     [64];
   logic [DW-1:0] ref_mem [64];

   int cyc = 0;
   int n_chk = 0;
   int n_err = 0;

   typedef struct {
      int            idx;
      logic [DW-1:0] data;
      int            due;
   } exp_t;
   exp_t sb[$];

   dpram_rr_arbiter_if #(.N(N), .AW(AW), .DW(DW)) bus ();

   dpram_rr_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .ram_addr_a (ram_addr_a),
      .ram_addr_b (ram_addr_b),
      .ram_data_a (ram_data_a),
      .ram_data_b (ram_data_b),
      .ram_we_a   (ram_we_a),
      .ram_we_b   (ram_we_b),
      .ram_q_a    (ram_q_a),
      .ram_q_b    (ram_q_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: synchronous write, registered read of old contents
   always @(posedge clk) begin
      if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
      if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
      ram_q_a <= mem[ram_addr_a];
      ram_q_b <= mem[ram_addr_b];
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic set_rq(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.we[i]              = w;
      bus.addr[i*AW +: AW]   = a;
      bus.wdata[i*DW +: DW]  = d;
      bus.req[i]             = 1'b1;
   endtask

   // Scoreboard: match responses, flag missing ones, record new grants
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < N; i++) begin
            if (bus.rvalid[i]) begin
               int k;
               k = -1;
               for (int e = 0; e < sb.size(); e++)
                  if (k < 0 && sb[e].idx == i) k = e;
               if (k < 0) begin
                  chk("rvalid_unexp", 32'(bus.rvalid[i]), 32'd0);
               end else begin
                  chk("sb_rdata", 32'(bus.rdata[i*DW +: DW]), 32'(sb[k].data));
                  chk("sb_latency", cyc, sb[k].due);
                  sb.delete(k);
               end
            end
         end
         for (int e = sb.size() - 1; e >= 0; e--) begin
            if (sb[e].due < cyc) begin
               chk("rvalid_miss", 32'(bus.rvalid[sb[e].idx]), 32'd1);
               sb.delete(e);
            end
         end
         for (int i = 0; i < N; i++)
            if (bus.gnt[i] && !bus.we[i])
               sb.push_back('{i, ref_mem[bus.addr[i*AW +: AW]], cyc + 2});
         for (int i = 0; i < N; i++)
            if (bus.gnt[i] && bus.we[i])
               ref_mem[bus.addr[i*AW +: AW]] = bus.wdata[i*DW +: DW];
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [3:0] pat [4];
      int served [N];
      pat = '{4'b0011, 4'b1100, 4'b0011, 4'b1100};
      for (int i = 0; i < 64; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      for (int i = 0; i < N; i++) served[i] = 0;
      rst_n     = 1'b0;
      bus.req   = '0;
      bus.we    = '0;
      bus.addr  = '0;
      bus.wdata = '0;
      tick();
      tick();
      mid();
      chk("rst_we_a", 32'(ram_we_a), 32'd0);
      chk("rst_we_b", 32'(ram_we_b), 32'd0);
      chk("rst_addr_a", 32'(ram_addr_a), 32'd0);
      chk("rst_data_b", 32'(ram_data_b), 32'd0);
      chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
      chk("rst_rdata", bus.rdata, 32'd0);
      chk("rst_ptr", 32'(dut.ptr), 32'd0);
      tick();
      rst_n = 1'b1;

      // dual write
      set_rq(0, 1'b1, 6'h01, 8'h33);
      set_rq(1, 1'b1, 6'h02, 8'h44);
      mid();
      chk("t1_gnt", 32'(bus.gnt), 32'b0011);
      tick();
      bus.req = '0;
      chk("t1_we_a", 32'(ram_we_a), 32'd1);
      chk("t1_we_b", 32'(ram_we_b), 32'd1);
      chk("t1_addr_a", 32'(ram_addr_a), 32'h01);
      chk("t1_addr_b", 32'(ram_addr_b), 32'h02);
      chk("t1_data_a", 32'(ram_data_a), 32'h33);
      chk("t1_data_b", 32'(ram_data_b), 32'h44);
      chk("t1_ptr", 32'(dut.ptr), 32'd2);

      // dual read of the freshly written words
      set_rq(2, 1'b0, 6'h01, 8'h00);
      set_rq(3, 1'b0, 6'h02, 8'h00);
      mid();
      chk("t2_gnt", 32'(bus.gnt), 32'b1100);
      tick();
      bus.req = '0;
      mid();
      chk("t2_rvalid_early", 32'(bus.rvalid), 32'd0);
      tick();
      mid();
      chk("t2_rvalid", 32'(bus.rvalid), 32'b1100);
      chk("t2_lane2", 32'(bus.rdata[2*DW +: DW]), 32'h33);
      chk("t2_lane3", 32'(bus.rdata[3*DW +: DW]), 32'h44);

      // write/read collision on one address
      tick();
      chk("t3_ptr", 32'(dut.ptr), 32'd0);
      set_rq(0, 1'b1, 6'h03, 8'h55);
      set_rq(1, 1'b0, 6'h03, 8'h00);
      mid();
      chk("t3_gnt", 32'(bus.gnt), 32'b0001);
      chk("t3_we_b_idle", 32'(ram_we_b), 32'd0);
      tick();
      bus.req[0] = 1'b0;
      chk("t3_port_b_blocked", 32'(ram_we_b), 32'd0);
      mid();
      chk("t3_gnt_retry", 32'(bus.gnt), 32'b0010);
      tick();
      bus.req = '0;
      mid();
      tick();
      mid();
      chk("t3_rvalid", 32'(bus.rvalid), 32'b0010);
      chk("t3_lane1", 32'(bus.rdata[1*DW +: DW]), 32'h55);

      // single request from r3 brings the pointer back to 0
      tick();
      set_rq(3, 1'b0, 6'h03, 8'h00);
      mid();
      chk("t3b_gnt", 32'(bus.gnt), 32'b1000);
      tick();
      bus.req = '0;
      chk("t3b_ptr", 32'(dut.ptr), 32'd0);

      // all four requesters held for four cycles
      set_rq(0, 1'b0, 6'h01, 8'h00);
      set_rq(1, 1'b0, 6'h02, 8'h00);
      set_rq(2, 1'b0, 6'h03, 8'h00);
      set_rq(3, 1'b0, 6'h04, 8'h00);
      for (int c = 0; c < 4; c++) begin
         mid();
         chk($sformatf("t4_gnt%0d", c), 32'(bus.gnt), 32'(pat[c]));
         for (int i = 0; i < N; i++) served[i] += int'(bus.gnt[i]);
         tick();
      end
      bus.req = '0;
      for (int i = 0; i < N; i++) chk($sformatf("t4_served%0d", i), served[i], 2);
      mid();
      tick();
      mid();
      tick();

      // two reads of the same address share the cycle
      set_rq(1, 1'b0, 6'h01, 8'h00);
      set_rq(2, 1'b0, 6'h01, 8'h00);
      mid();
      chk("t5_gnt", 32'(bus.gnt), 32'b0110);
      tick();
      bus.req = '0;
      mid();
      tick();
      mid();
      chk("t5_rvalid", 32'(bus.rvalid), 32'b0110);
      chk("t5_lane1", 32'(bus.rdata[1*DW +: DW]), 32'h33);
      chk("t5_lane2", 32'(bus.rdata[2*DW +: DW]), 32'h33);

      // reset while a read is in flight
      tick();
      set_rq(0, 1'b0, 6'h02, 8'h00);
      mid();
      chk("t6_gnt", 32'(bus.gnt), 32'b0001);
      tick();
      bus.req = '0;
      set_rq(1, 1'b0, 6'h01, 8'h00);
      rst_n = 1'b0;
      sb.delete();
      mid();
      chk("t6_gnt_in_rst", 32'(bus.gnt), 32'd0);
      chk("t6_rvalid_in_rst", 32'(bus.rvalid), 32'd0);
      chk("t6_we_a_in_rst", 32'(ram_we_a), 32'd0);
      tick();
      rst_n   = 1'b1;
      bus.req = '0;
      chk("t6_ptr", 32'(dut.ptr), 32'd0);
      chk("t6_we_a", 32'(ram_we_a), 32'd0);
      chk("t6_we_b", 32'(ram_we_b), 32'd0);
      for (int c = 0; c < 3; c++) begin
         mid();
         chk($sformatf("t6_rvalid%0d", c), 32'(bus.rvalid), 32'd0);
         tick();
      end

      repeat (3) tick();
      mid();
      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/dpram_rr_arbiter.md
Name: dpram_rr_arbiter

Overview:
- Shares the two ports of the existing 64x8 dual_port_ram between N requesters.
- Each cycle it grants up to two requests using round-robin priority and steers them onto RAM ports A and B.
- It blocks same-address collisions and routes registered read data back to the originating requester.
- It sits between requester logic and the RAM instance at the same hierarchy level and drives the RAM's data_a/b, addr_a/b and we_a/b pins.

Parameters:
- N, 4, number of requesters (2..8)
- AW, 6, RAM address width
- DW, 8, RAM data width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  N  request per requester; held until granted
- we  in  N  1 = write, 0 = read, per requester
- addr  in  N*AW  flattened addresses; requester i at [i*AW +: AW]
- wdata  in  N*DW  flattened write data
- gnt  out  N  combinational grant; request consumed this cycle
- rvalid  out  N  read data valid pulse per requester
- rdata  out  N*DW  flattened read data; valid only with rvalid[i]
- ram_addr_a, ram_addr_b  out  AW  to RAM addr_a/addr_b
- ram_data_a, ram_data_b  out  DW  to RAM data_a/data_b
- ram_we_a, ram_we_b  out  1  to RAM we_a/we_b
- ram_q_a, ram_q_b  in  DW  from RAM q_a/q_b

Behaviour:
- RAM model: addr, data and we are sampled on the clk rising edge. q is registered, so a read launched at edge E is valid after E.
- Arbitration, combinational in cycle T:
  - Scan req from ptr upward, modulo N.
  - First requester found = primary, assigned to port A. Next requester found = secondary, assigned to port B.
- Conflict rule: secondary is not granted if addr(secondary) == addr(primary) and either request is a write. Two reads to the same address are both granted.
- gnt[i] = 1 only for granted requesters. At most 2 bits are set. gnt is 0 for any requester with req = 0.
- Pointer: after a cycle with grants, ptr <= (index of the last granted requester + 1) mod N. With no grants, ptr holds.
- Stage 1, at the edge ending T:
  - Granted A request loads ram_addr_a, ram_data_a, ram_we_a, plus tag_a = {valid, is_read, requester index}.
  - Same for the B port.
  - Ungranted port: ram_we_x <= 0 and tag valid <= 0. Address and data hold their previous values.
- RAM access happens at the edge ending T+1. Tags advance to stage 2 at the same edge.
- Stage 2, cycle T+2:
  - For each port whose tag is valid and is_read: rvalid[idx] = 1 and rdata[idx] = ram_q_x.
  - Writes produce no response.
- Read latency is 2 cycles from the grant cycle. Throughput is 2 requests per cycle.
- The A and B tags always carry different indices, so rvalid never has a same-index collision.
- rvalid and rdata are registered outputs. rdata lanes not pulsing hold their last value.
- Ordering:
  - A write granted in T is visible to any read granted in T+1 or later.
  - A same-cycle write/read pair on one address is impossible because of the conflict rule.
- Requester changing addr/we/wdata while req is high and before gnt: the new values are used. Dropping req before gnt withdraws the request.
- Reset values, asynchronous when rst_n = 0:
  - ptr = 0, gnt = 0.
  - ram_we_a = ram_we_b = 0, ram_addr_* = 0, ram_data_* = 0.
  - All tags invalid, rvalid = 0, rdata = 0.
- Reset mid-operation: in-flight reads are dropped with no rvalid. Writes already registered at stage 1 but not yet clocked into the RAM are lost.
- While rst_n = 0, gnt must be 0 even if req is high.

Decomposition:
- Package dpram_arb_pkg holds: DEF_N, DEF_AW, DEF_DW, and the tag field layout (TAG_VALID, TAG_RD, TAG_IDX width = clog2(N)).
- Sub-module rr_pick2: combinational. Takes req and ptr; outputs primary/secondary one-hot vectors and their valid flags.
- Conflict masking, stage registers and response routing stay in dpram_rr_arbiter.

Test Plan:
1. After reset, req=4'b0011, we=4'b0011, writes 0x33→addr 0x01 (r0) and 0x44→addr 0x02 (r1) -> gnt=0011 in the same cycle; next cycle ram_we_a=ram_we_b=1 with addr 0x01/0x02; ptr=2.
2. Next cycle, r2 reads 0x01 and r3 reads 0x02 -> gnt=1100; two cycles later rvalid=1100 with rdata lane 2 = 0x33 and lane 3 = 0x44.
3. Conflict: r0 writes 0x55→0x03 and r1 reads 0x03 with ptr=0 -> gnt=0001. r1 is granted the following cycle and its rvalid returns rdata 0x55.
4. All four req held high for 4 cycles with distinct addresses -> grants 0011, 1100, 0011, 1100; each requester served twice; no starvation.
5. Same-address dual read: r1 and r2 read 0x01 -> both granted in one cycle; rvalid=0110 with both lanes 0x33.
6. Read granted, then rst_n pulled low for 1 cycle before the data returns -> rvalid stays 0, gnt=0 during reset, ptr=0 and ram_we_*=0 after release.
